logo_fm_loader: RTL and testbench

// Boot-time loader sitting directly upstream of the 16 KB FM logo RAM.

---
 rtl/logo_fm_loader.sv | 126 ++++++++++++
 tb/tb_logo_fm_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logo_fm_loader.sv
// Boot-time loader for the FM logo RAM: streams the flash image into the RAM one byte per write,
// then hands the RAM port to the CPU slot. Reports done, timeout error and an additive checksum.
module logo_fm_loader #(
    parameter int unsigned ADDR_W     = 14,
    parameter logic [23:0] FLASH_BASE = 24'h700000,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
    input  logic              clock,
    input  logic              reset,
    output logic              flash_rd,
    output logic [23:0]       flash_addr,
    input  logic              flash_valid,
    input  logic [7:0]        flash_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    input  logic [7:0]        ram_q,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [7:0]        cpu_data,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_q,
    output logic              load_done,
    output logic              load_error,
    output logic [7:0]        load_sum
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWrite,
        StDone,
        StError
    } state_e;

    localparam logic [ADDR_W-1:0] LastIndex = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [15:0]       tmo_inc;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        sum_q, sum_d;

    assign tmo_inc = tmo_q + 16'd1;

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            index_q <= '0;
            tmo_q   <= '0;
            byte_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            tmo_q   <= tmo_d;
            byte_q  <= byte_d;
            sum_q   <= sum_d;
        end
    end

    // Next-state logic and RAM port ownership.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        tmo_d       = tmo_q;
        byte_d      = byte_q;
        sum_d       = sum_q;
        flash_rd    = 1'b0;
        ram_address = index_q;
        ram_data    = byte_q;
        ram_wren    = 1'b0;
        load_done   = 1'b0;
        load_error  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmo_d   = '0;
                state_d = StReq;
            end
            StReq: begin
                flash_rd = 1'b1;
                // A strobe on the expiry cycle still counts as a successful fetch.
                if (flash_valid) begin
                    byte_d  = flash_data;
                    tmo_d   = '0;
                    state_d = StWrite;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc >= TIMEOUT) begin
                        state_d = StError;
                    end
                end
            end
            StWrite: begin
                ram_wren = 1'b1;
                sum_d    = sum_q + byte_q;
                if (index_q == LastIndex) begin
                    state_d = StDone;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                    state_d = StReq;
                end
            end
            StDone: begin
                load_done   = 1'b1;
                ram_address = cpu_address;
                ram_data    = cpu_data;
                ram_wren    = cpu_wr;
            end
            StError: begin
                load_error = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Index is zero-extended into the 24-bit flash space; the add wraps at 24 bits.
    assign flash_addr = FLASH_BASE + 24'(index_q);
    assign cpu_q      = (state_q == StDone) ? ram_q : 8'hFF;
    assign load_sum   = sum_q;

endmodule

// File: tb/tb_logo_fm_loader.sv
// Self-checking bench for logo_fm_loader: randomized flash image, latency and CPU noise,
// with a behavioural RAM and flash model and an image-level reference for the checks.
module tb_logo_fm_loader;

    localparam int          AW   = 10;
    localparam int          N    = 1 << AW;
    localparam logic [15:0] TMO  = 16'd40;
    localparam logic [23:0] BASE = 24'h700000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flash_rd;
    logic [23:0]   flash_addr;
    logic          flash_valid = 1'b0;
    logic [7:0]    flash_data = 8'h00;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data;
    logic          ram_wren;
    logic [7:0]    ram_q = 8'h00;
    logic [AW-1:0] cpu_address = '0;
    logic [7:0]    cpu_data = 8'h00;
    logic          cpu_wr = 1'b0;
    logic [7:0]    cpu_q;
    logic          load_done;
    logic          load_error;
    logic [7:0]    load_sum;

    logo_fm_loader #(
        .ADDR_W    (AW),
        .FLASH_BASE(BASE),
        .TIMEOUT   (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flash_rd   (flash_rd),
        .flash_addr (flash_addr),
        .flash_valid(flash_valid),
        .flash_data (flash_data),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q),
        .cpu_address(cpu_address),
        .cpu_data   (cpu_data),
        .cpu_wr     (cpu_wr),
        .cpu_q      (cpu_q),
        .load_done  (load_done),
        .load_error (load_error),
        .load_sum   (load_sum)
    );

    always #5 clock = ~clock;

    // Flash image and test configuration (written by the stimulus tasks only).
    logic [7:0] img [0:N-1];
    int         special_idx = -1;
    int         special_lat = 0;   // 0: never answers
    bit         spurious    = 1'b0;
    bit         cpu_noise   = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cpuq_bad = 0;

    // Behavioural RAM with one-cycle registered read.
    logic [7:0] mem [0:N-1];
    always @(posedge clock) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    // Flash model: answers each request after a random latency of 1..5 cycles.
    int req_cnt = 0;
    int lat_cur = 1;
    always @(negedge clock) begin
        int idx;
        idx = int'(flash_addr - BASE);
        if (flash_rd && !reset) begin
            req_cnt++;
            if (req_cnt == 1)
                lat_cur = (idx == special_idx) ? special_lat : int'($urandom_range(1, 5));
            if (lat_cur != 0 && req_cnt == lat_cur) begin
                flash_valid = 1'b1;
                flash_data  = img[idx % N];
                req_cnt     = 0;
            end else begin
                flash_valid = 1'b0;
                flash_data  = 8'($urandom);
            end
        end else begin
            req_cnt     = 0;
            flash_valid = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            flash_data  = 8'($urandom);
        end
    end

    // Write monitor: expects loader writes in order 0,1,2,... carrying the image bytes.
    int wr_cnt = 0, wr_bad = 0, done_rises = 0, wren_err = 0, spc_cycles = 0, exp_idx = 0;
    bit prev_done = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            wr_cnt = 0; wr_bad = 0; done_rises = 0; wren_err = 0; spc_cycles = 0;
            exp_idx = 0; prev_done = 1'b0;
        end else begin
            if (ram_wren && !load_done && !load_error) begin
                wr_cnt++;
                if (exp_idx >= N || ram_address != AW'(exp_idx) || ram_data != img[exp_idx])
                    wr_bad++;
                exp_idx++;
            end
            if (load_error && ram_wren) wren_err++;
            if (load_done && !prev_done) done_rises++;
            prev_done = load_done;
            if (flash_rd && int'(flash_addr - BASE) == special_idx) spc_cycles++;
        end
    end

    function automatic logic [7:0] model_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(img[i]);
        return 8'(s % 256);
    endfunction

    task automatic new_image();
        for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        cpu_wr = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (!load_done && cpu_q !== 8'hFF) cpuq_bad++;
            if (load_done || load_error) begin
                ok = 1'b1;
                cpu_wr = 1'b0;
                break;
            end
            if (cpu_noise) begin
                cpu_wr      = 1'($urandom_range(0, 1));
                cpu_address = AW'($urandom);
                cpu_data    = 8'($urandom);
            end
        end
        cpu_wr = 1'b0;
    endtask

    function automatic int image_errors();
        int e = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== img[i]) e++;
        return e;
    endfunction

    task automatic test_reset();
        new_image();
        special_idx = -1;
        apply_reset();
        n_checks++; if (load_done !== 1'b0) $display("FAIL reset_done: got %b want 0", load_done); else n_pass++;
        n_checks++; if (load_error !== 1'b0) $display("FAIL reset_error: got %b want 0", load_error); else n_pass++;
        n_checks++; if (load_sum !== 8'h00) $display("FAIL reset_sum: got %h want 00", load_sum); else n_pass++;
        n_checks++; if (flash_rd !== 1'b0 || ram_wren !== 1'b0)
            $display("FAIL reset_strobes: got rd=%b wren=%b want 0 0", flash_rd, ram_wren); else n_pass++;
        n_checks++; if (cpu_q !== 8'hFF) $display("FAIL reset_cpu_q: got %h want ff", cpu_q); else n_pass++;
        n_checks++; if (flash_addr !== BASE) $display("FAIL reset_addr: got %h want %h", flash_addr, BASE); else n_pass++;
    endtask

    task automatic test_full_load();
        bit ok;
        spurious = 1'b1; cpu_noise = 1'b1; cpuq_bad = 0;
        wait_end(20000, ok);
        spurious = 1'b0; cpu_noise = 1'b0;
        n_checks++; if (!ok || load_done !== 1'b1) $display("FAIL full_done: got %b want 1", load_done); else n_pass++;
        n_checks++; if (load_error !== 1'b0) $display("FAIL full_error: got %b want 0", load_error); else n_pass++;
        n_checks++; if (wr_cnt != N) $display("FAIL full_writes: got %0d want %0d", wr_cnt, N); else n_pass++;
        n_checks++; if (wr_bad != 0) $display("FAIL full_write_order: got %0d bad want 0", wr_bad); else n_pass++;
        n_checks++; if (load_sum !== model_sum(N)) $display("FAIL full_sum: got %h want %h", load_sum, model_sum(N)); else n_pass++;
        n_checks++; if (image_errors() != 0) $display("FAIL full_image: got %0d bad bytes want 0", image_errors()); else n_pass++;
        n_checks++; if (cpuq_bad != 0) $display("FAIL full_cpu_q_ff: got %0d bad cycles want 0", cpuq_bad); else n_pass++;
        repeat (5) @(negedge clock);
        n_checks++; if (done_rises != 1) $display("FAIL full_done_once: got %0d want 1", done_rises); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        new_image();
        special_idx = 100; special_lat = 0;
        apply_reset();
        wait_end(20000, ok);
        n_checks++; if (!ok || load_error !== 1'b1) $display("FAIL tmo_error: got %b want 1", load_error); else n_pass++;
        n_checks++; if (load_done !== 1'b0) $display("FAIL tmo_done: got %b want 0", load_done); else n_pass++;
        n_checks++; if (spc_cycles != int'(TMO)) $display("FAIL tmo_wait_cycles: got %0d want %0d", spc_cycles, TMO); else n_pass++;
        n_checks++; if (wr_cnt != 100) $display("FAIL tmo_writes: got %0d want 100", wr_cnt); else n_pass++;
        n_checks++; if (load_sum !== model_sum(100)) $display("FAIL tmo_sum: got %h want %h", load_sum, model_sum(100)); else n_pass++;
        cpu_address = '0; cpu_data = ~img[0]; cpu_wr = 1'b1;
        repeat (10) @(negedge clock);
        n_checks++; if (flash_rd !== 1'b0) $display("FAIL tmo_flash_rd: got %b want 0", flash_rd); else n_pass++;
        n_checks++; if (cpu_q !== 8'hFF) $display("FAIL tmo_cpu_q: got %h want ff", cpu_q); else n_pass++;
        n_checks++; if (wren_err != 0) $display("FAIL tmo_no_wren: got %0d writes want 0", wren_err); else n_pass++;
        n_checks++; if (mem[0] !== img[0]) $display("FAIL tmo_cpu_wr_ignored: got %h want %h", mem[0], img[0]); else n_pass++;
        cpu_wr = 1'b0;
    endtask

    task automatic test_timeout_edge();
        bit ok;
        special_idx = 7; special_lat = int'(TMO);
        apply_reset();
        wait_end(20000, ok);
        n_checks++; if (!ok || load_done !== 1'b1 || load_error !== 1'b0)
            $display("FAIL edge_valid_wins: got done=%b err=%b want 1 0", load_done, load_error); else n_pass++;
        n_checks++; if (load_sum !== model_sum(N)) $display("FAIL edge_sum: got %h want %h", load_sum, model_sum(N)); else n_pass++;
        special_lat = int'(TMO) + 1;
        apply_reset();
        wait_end(20000, ok);
        n_checks++; if (!ok || load_error !== 1'b1 || wr_cnt != 7)
            $display("FAIL edge_late_valid: got err=%b writes=%0d want 1 7", load_error, wr_cnt); else n_pass++;
        special_idx = -1;
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        int guard = 0;
        apply_reset();
        while (exp_idx < 500 && guard < 10000) begin
            @(negedge clock);
            guard++;
        end
        n_checks++; if (exp_idx < 500) $display("FAIL mid_reach_500: got %0d want 500", exp_idx); else n_pass++;
        @(posedge clock); #1;
        reset = 1'b1;
        new_image();
        @(posedge clock); #1;
        n_checks++; if (flash_addr !== BASE || load_sum !== 8'h00)
            $display("FAIL mid_restart: got addr=%h sum=%h want %h 00", flash_addr, load_sum, BASE); else n_pass++;
        reset = 1'b0;
        wait_end(20000, ok);
        n_checks++; if (!ok || load_done !== 1'b1 || wr_cnt != N)
            $display("FAIL mid_reload: got done=%b writes=%0d want 1 %0d", load_done, wr_cnt, N); else n_pass++;
        n_checks++; if (load_sum !== model_sum(N)) $display("FAIL mid_sum: got %h want %h", load_sum, model_sum(N)); else n_pass++;
        n_checks++; if (image_errors() != 0) $display("FAIL mid_image: got %0d bad bytes want 0", image_errors()); else n_pass++;
    endtask

    task automatic test_cpu_access();
        logic [AW-1:0] a;
        logic [7:0]    want;
        @(negedge clock);
        cpu_address = '1; cpu_data = 8'hC3; cpu_wr = 1'b1;
        @(negedge clock);
        cpu_wr = 1'b0;
        @(negedge clock);
        n_checks++; if (cpu_q !== 8'hC3) $display("FAIL cpu_rw_top: got %h want c3", cpu_q); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            a = AW'($urandom);
            cpu_address = a;
            want = (a == '1) ? 8'hC3 : img[a];
            @(negedge clock);
            n_checks++; if (cpu_q !== want) $display("FAIL cpu_read[%0d]: addr %h got %h want %h", k, a, cpu_q, want); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_load();
        test_cpu_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
